// File: rtl/hsi_div_sched_if.sv
// Pixel-in / HSI-out handshake bundle between an upstream source and hsi_div_sched.
// Latency: none, wiring only.
// Backpressure: valid/ready in both directions; master is the upstream/downstream side.
interface hsi_div_sched_if;
   logic       iValid;
   logic       oReady;
   logic [7:0] iR;
   logic [7:0] iG;
   logic [7:0] iB;
   logic       oValid;
   logic       iReady;
   logic [8:0] oHue;
   logic [7:0] oSaturation;
   logic [7:0] oIntensity;

   modport master (
      output iValid, iR, iG, iB, iReady,
      input  oReady, oValid, oHue, oSaturation, oIntensity
   );

   modport slave (
      input  iValid, iR, iG, iB, iReady,
      output oReady, oValid, oHue, oSaturation, oIntensity
   );
endinterface

// File: rtl/hsi_div_sched.sv
// RGB -> HSI converter sharing one 18-step restoring divider across intensity, saturation and hue.
// Latency: pixel accepted at edge T, oValid first seen high at edge T+55, independent of data.
// Backpressure: one pixel in flight; oReady only in IDLE, results held in DONE until iReady.
module hsi_div_sched (
   input  logic           iCLK,
   input  logic           iRST,
   hsi_div_sched_if.slave bus
);
   typedef enum logic [2:0] {IDLE, DIV_I, DIV_S, DIV_H, DONE} state_t;
   localparam logic [4:0] LAST_STEP = 5'd17;

   state_t      state, state_nxt;
   logic        rdy, vld;
   logic [7:0]  pix_r, pix_g, pix_b;

   // divider state: step counter, partial remainder, quotient shift register
   logic [4:0]  cnt;
   logic [9:0]  rem;
   logic [17:0] quo;

   // intermediate and final results
   logic [7:0]  int_hold, sat_hold;
   logic [8:0]  hue_out;
   logic [7:0]  sat_out, int_out;

   // pixel-derived operands
   logic [9:0]  sum;
   logic [7:0]  mn;
   logic        gray;
   logic [7:0]  hue_diff;
   logic [9:0]  hue_den;
   logic [8:0]  hue_off;
   logic [17:0] sat_num, hue_num;

   // divider datapath
   logic [17:0] dvd;
   logic [9:0]  dvs;
   logic [4:0]  idx;
   logic [9:0]  rem_cur;
   logic [10:0] trial, diff;
   logic        ge;
   logic [9:0]  rem_nxt;
   logic [17:0] quo_nxt, res;
   logic        last;
   logic        unused_bits;

   // Operand preparation from the captured pixel: sum, min and hue sector terms.
   always_comb begin
      sum      = {2'b00, pix_r} + {2'b00, pix_g} + {2'b00, pix_b};
      gray     = (pix_r == pix_g) && (pix_g == pix_b);
      mn       = pix_b;
      if ((pix_r <= pix_g) && (pix_r <= pix_b))
         mn = pix_r;
      else if ((pix_g < pix_r) && (pix_g <= pix_b))
         mn = pix_g;
      hue_diff = '0;
      hue_den  = '0;
      hue_off  = '0;
      if (gray) begin
         hue_diff = '0;
         hue_den  = '0;
         hue_off  = 9'd0;
      end else if (mn == pix_b) begin
         hue_diff = pix_g - pix_b;
         hue_den  = {2'b00, pix_r} + {2'b00, pix_g} - {1'b0, pix_b, 1'b0};
         hue_off  = 9'd0;
      end else if (mn == pix_r) begin
         hue_diff = pix_b - pix_r;
         hue_den  = {2'b00, pix_b} + {2'b00, pix_g} - {1'b0, pix_r, 1'b0};
         hue_off  = 9'd120;
      end else begin
         hue_diff = pix_r - pix_g;
         hue_den  = {2'b00, pix_r} + {2'b00, pix_b} - {1'b0, pix_g, 1'b0};
         hue_off  = 9'd240;
      end
      sat_num  = 18'd765 * {10'd0, mn};
      hue_num  = 18'd120 * {10'd0, hue_diff};
   end

   // One restoring-division step per cycle, dividend bits consumed MSB first.
   always_comb begin
      dvd = '0;
      dvs = '0;
      case (state)
         DIV_I:   begin dvd = {8'd0, sum}; dvs = 10'd3;   end
         DIV_S:   begin dvd = sat_num;     dvs = sum;     end
         DIV_H:   begin dvd = hue_num;     dvs = hue_den; end
         default: begin dvd = '0;          dvs = '0;      end
      endcase
      idx     = LAST_STEP - cnt;
      rem_cur = (cnt == 5'd0) ? 10'd0 : rem;
      trial   = {rem_cur, dvd[idx]};
      diff    = trial - {1'b0, dvs};
      ge      = trial >= {1'b0, dvs};
      rem_nxt = ge ? diff[9:0] : trial[9:0];
      quo_nxt = {quo[16:0], ge};
      // a zero divisor still runs all steps but yields a defined zero
      res     = (dvs == 10'd0) ? 18'd0 : quo_nxt;
      last    = (cnt == LAST_STEP);
   end

   assign unused_bits = ^{quo[17], res[17:9], diff[10]};

   // Sequencer next state and handshake outputs.
   always_comb begin
      state_nxt = state;
      rdy       = 1'b0;
      vld       = 1'b0;
      case (state)
         IDLE: begin
            rdy = 1'b1;
            if (bus.iValid) state_nxt = DIV_I;
         end
         DIV_I: if (last) state_nxt = DIV_S;
         DIV_S: if (last) state_nxt = DIV_H;
         DIV_H: if (last) state_nxt = DONE;
         DONE: begin
            vld = 1'b1;
            if (bus.iReady) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state <= IDLE;
      else      state <= state_nxt;
   end

   // Capture the pixel only on an accepted handshake.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         pix_r <= '0;
         pix_g <= '0;
         pix_b <= '0;
      end else if ((state == IDLE) && bus.iValid) begin
         pix_r <= bus.iR;
         pix_g <= bus.iG;
         pix_b <= bus.iB;
      end
   end

   // Advance the shared divider while in any division state.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         cnt <= '0;
         rem <= '0;
         quo <= '0;
      end else if ((state == DIV_I) || (state == DIV_S) || (state == DIV_H)) begin
         cnt <= last ? 5'd0 : cnt + 5'd1;
         rem <= rem_nxt;
         quo <= quo_nxt;
      end else begin
         cnt <= '0;
      end
   end

   // Bank each quotient; publish all three outputs together on entry to DONE.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         int_hold <= '0;
         sat_hold <= '0;
         hue_out  <= '0;
         sat_out  <= '0;
         int_out  <= '0;
      end else if (last) begin
         case (state)
            DIV_I: int_hold <= res[7:0];
            DIV_S: sat_hold <= (sum == 10'd0) ? 8'd0 : 8'd255 - res[7:0];
            DIV_H: begin
               hue_out <= hue_off + res[8:0];
               sat_out <= sat_hold;
               int_out <= int_hold;
            end
            default: ;
         endcase
      end
   end

   assign bus.oReady      = rdy;
   assign bus.oValid      = vld;
   assign bus.oHue        = hue_out;
   assign bus.oSaturation = sat_out;
   assign bus.oIntensity  = int_out;
endmodule

// File: tb/tb_hsi_div_sched.sv
// Directed and random bench for hsi_div_sched.
// Latency: checks accept-to-valid distance of 55 edges.
// Backpressure: exercises DONE hold with iReady low and a rejected iValid pulse.
module tb_hsi_div_sched;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passes = 0;

   hsi_div_sched_if bus();

   hsi_div_sched dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === 32'(exp)) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic void model(input int r, input int g, input int b,
                                 output int h, output int s, output int i);
      int sum, mn;
      sum = r + g + b;
      i   = sum / 3;
      if (r <= g && r <= b)     mn = r;
      else if (g < r && g <= b) mn = g;
      else                      mn = b;
      s = (sum == 0) ? 0 : 255 - (765 * mn) / sum;
      if (r == g && g == b)  h = 0;
      else if (mn == b)      h = (120 * (g - b)) / (r + g - 2 * b);
      else if (mn == r)      h = (120 * (b - r)) / (b + g - 2 * r) + 120;
      else                   h = (120 * (r - g)) / (r + b - 2 * g) + 240;
   endfunction

   // Called at a negedge; returns at the negedge where oValid is first seen high.
   task automatic convert(input int r, input int g, input int b, input bit drop_valid,
                          output int lat);
      int guard;
      logic [31:0] rv, gv, bv;
      rv = r; gv = g; bv = b;
      guard = 0;
      bus.iR = rv[7:0];
      bus.iG = gv[7:0];
      bus.iB = bv[7:0];
      bus.iValid = 1'b1;
      while (bus.oReady !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("accept_ready", {31'd0, bus.oReady}, 1);
      @(posedge clk);
      lat = 0;
      @(negedge clk);
      if (drop_valid) bus.iValid = 1'b0;
      while (bus.oValid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      lat = lat + 1;
   endtask

   task automatic release_result(input string tag);
      bus.iReady = 1'b1;
      @(negedge clk);
      check({tag, "_exit_valid"}, {31'd0, bus.oValid}, 0);
      check({tag, "_exit_ready"}, {31'd0, bus.oReady}, 1);
      bus.iReady = 1'b0;
   endtask

   task automatic directed(input string tag, input int r, input int g, input int b,
                           input int h, input int s, input int i);
      int lat;
      convert(r, g, b, 1'b1, lat);
      check({tag, "_latency"}, lat, 55);
      check({tag, "_hue"}, {23'd0, bus.oHue}, h);
      check({tag, "_sat"}, {24'd0, bus.oSaturation}, s);
      check({tag, "_int"}, {24'd0, bus.oIntensity}, i);
      release_result(tag);
   endtask

   initial begin
      int lat, r, g, b, h, s, i;

      rst        = 1'b1;
      bus.iValid = 1'b0;
      bus.iReady = 1'b0;
      bus.iR     = '0;
      bus.iG     = '0;
      bus.iB     = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, bus.oReady}, 1);
      check("rst_valid", {31'd0, bus.oValid}, 0);
      check("rst_hue",   {23'd0, bus.oHue}, 0);
      check("rst_sat",   {24'd0, bus.oSaturation}, 0);
      check("rst_int",   {24'd0, bus.oIntensity}, 0);
      rst = 1'b0;

      // primaries, grey, black and a mixed colour
      directed("red",   255,   0,   0,   0, 255,  85);
      directed("green",   0, 255,   0, 120, 255,  85);
      directed("blue",    0,   0, 255, 240, 255,  85);
      directed("grey",  100, 100, 100,   0,   0, 100);
      directed("mixed", 200, 100,  50,  30, 146, 116);
      directed("black",   0,   0,   0,   0,   0,   0);

      // backpressure: hold DONE for 10 cycles, pulse a pixel that must be ignored
      convert(200, 100, 50, 1'b1, lat);
      check("bp_latency", lat, 55);
      for (int k = 0; k < 10; k++) begin
         if (k == 3) begin
            bus.iR = 8'd1; bus.iG = 8'd2; bus.iB = 8'd3;
            bus.iValid = 1'b1;
         end else begin
            bus.iValid = 1'b0;
         end
         @(negedge clk);
         check("bp_valid", {31'd0, bus.oValid}, 1);
         check("bp_ready", {31'd0, bus.oReady}, 0);
         check("bp_hue",   {23'd0, bus.oHue}, 30);
         check("bp_sat",   {24'd0, bus.oSaturation}, 146);
         check("bp_int",   {24'd0, bus.oIntensity}, 116);
      end
      bus.iValid = 1'b0;
      release_result("bp");
      check("bp_hold_hue", {23'd0, bus.oHue}, 30);
      @(negedge clk);
      check("bp_still_idle", {31'd0, bus.oReady}, 1);

      // reset at cycle 20 of a conversion, then an immediate new pixel
      bus.iR = 8'd10; bus.iG = 8'd20; bus.iB = 8'd30;
      bus.iValid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.iValid = 1'b0;
      repeat (19) @(negedge clk);
      check("mid_busy", {31'd0, bus.oReady}, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", {31'd0, bus.oReady}, 1);
      check("mid_rst_valid", {31'd0, bus.oValid}, 0);
      check("mid_rst_hue",   {23'd0, bus.oHue}, 0);
      check("mid_rst_sat",   {24'd0, bus.oSaturation}, 0);
      check("mid_rst_int",   {24'd0, bus.oIntensity}, 0);
      @(negedge clk);
      rst = 1'b0;
      directed("after_rst", 30, 60, 90, 200, 128, 60);

      // random sweep, iValid and iReady held high throughout
      bus.iReady = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         r = $urandom_range(0, 255);
         g = $urandom_range(0, 255);
         b = $urandom_range(0, 255);
         if (n % 8 == 0) g = r;
         if (n % 8 == 1) b = g;
         if (n % 8 == 2) b = r;
         model(r, g, b, h, s, i);
         convert(r, g, b, 1'b0, lat);
         check("sweep_latency", lat, 55);
         check("sweep_hue", {23'd0, bus.oHue}, h);
         check("sweep_sat", {24'd0, bus.oSaturation}, s);
         check("sweep_int", {24'd0, bus.oIntensity}, i);
      end
      bus.iValid = 1'b0;
      bus.iReady = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/hsi_div_sched.md
HSI_DIV_SCHED -- requirements
Module: hsi_div_sched

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: iCLK and iRST.
REQ-002 SHALL have port iCLK, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have port iRST, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port iValid, input, 1 bit: input pixel present.
REQ-005 SHALL have port oReady, output, 1 bit: block can accept a pixel.
REQ-006 SHALL have ports iR, iG and iB, inputs, 8 bits each: pixel colour components.
REQ-007 SHALL have port oValid, output, 1 bit: result present.
REQ-008 SHALL have port iReady, input, 1 bit: downstream accepts the result.
REQ-009 SHALL have port oHue, output, 9 bits: hue, range 0..360.
REQ-010 SHALL have ports oSaturation and oIntensity, outputs, 8 bits each: saturation and intensity.

Function
REQ-011 SHALL compute HSI for one pixel at a time using one shared, iterative, restoring divider (18-bit dividend, 10-bit divisor, 18-bit quotient, one quotient bit per cycle, MSB first).
REQ-012 SHALL use FSM states IDLE, DIV_I, DIV_S, DIV_H and DONE, and SHALL assert oReady only in IDLE.
REQ-013 SHALL, on handshake (iValid & oReady at edge T), register iR/iG/iB and move IDLE->DIV_I; iR/iG/iB SHALL be ignored at all other times.
REQ-014 SHALL spend exactly 18 cycles in each of DIV_I, DIV_S and DIV_H, in that order, then enter DONE; oValid SHALL first be high at the edge T+55, a fixed latency independent of data.
REQ-015 SHALL hold oValid high in DONE with stable outputs until iReady=1, then go DONE->IDLE (oValid=0, oReady=1 the next cycle); accepts SHALL NOT overlap with DONE.
REQ-016 SHALL compute sum = R+G+B as 10 bits; Intensity SHALL be floor(sum/3), computed in DIV_I.
REQ-017 SHALL select min as: R if R<=G and R<=B; else G if G<R and G<=B; else B.
REQ-018 SHALL compute Saturation in DIV_S as 255 - floor(765*min/sum), with dividend 765*min as 18 bits; Saturation SHALL be forced to 0 when sum==0.
REQ-019 SHALL compute Hue in DIV_H, choosing the first true case:
  - R==G==B: 0.
  - min==B: floor(120*(G-B)/(R+G-2B)).
  - min==R: floor(120*(B-R)/(B+G-2R))+120.
  - else: floor(120*(R-G)/(R+B-2G))+240.
REQ-020 SHALL use an 18-bit hue numerator and a 10-bit denominator, and SHALL add the offset after the division.
REQ-021 SHALL, whenever a divisor is 0, still run the full 18 cycles and force the defined result (0).
REQ-022 SHALL register oHue, oSaturation and oIntensity together on entry to DONE, and SHALL hold those values until the next DONE entry.
REQ-023 SHALL truncate results to output width; no overflow SHALL occur for any 8-bit input.

Reset
REQ-024 SHALL, while iRST=1, hold the FSM in IDLE with oReady=1, oValid=0, oHue=0, oSaturation=0, oIntensity=0, and the divider registers cleared.
REQ-025 SHALL, when iRST asserts mid-operation, immediately abandon the operation in progress, discard the pixel in flight, and produce no oValid pulse for it.
REQ-026 SHALL accept a pixel at the first rising edge after iRST deasserts.

Verification
REQ-027 SHALL cover reset: assert iRST -> oReady=1, oValid=0, all outputs 0; then assert iRST at cycle 20 of a conversion -> no oValid for that pixel, next pixel converts correctly.
REQ-028 SHALL cover R=255,G=0,B=0 accepted at T -> oValid first high at T+55, Hue=0, Saturation=255, Intensity=85.
REQ-029 SHALL cover (0,255,0) -> Hue=120, Saturation=255, Intensity=85; and (0,0,255) -> Hue=240, Saturation=255, Intensity=85.
REQ-030 SHALL cover (100,100,100) -> Hue=0, Saturation=0, Intensity=100; and (0,0,0) -> all outputs 0, with latency still 55.
REQ-031 SHALL cover backpressure: iReady held 0 for 10 cycles after oValid -> outputs stable, oReady=0, and an iValid pulse during that window is not accepted; iReady=1 -> IDLE next cycle.
REQ-032 SHALL cover a random sweep of 1000 pixels compared against a floor-arithmetic model of REQ-016..REQ-019, with back-to-back iValid held high throughout.
